// File: rtl/mips_decode_pkg.sv
// Shared decode constants and the decoded-entry bundle
// for the buffered MIPS decode stage.
package mips_decode_pkg;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  localparam logic [5:0] OP0_ADD  = 6'h20;
  localparam logic [5:0] OP0_ADDU = 6'h21;
  localparam logic [5:0] OP0_SUB  = 6'h22;
  localparam logic [5:0] OP0_AND  = 6'h24;
  localparam logic [5:0] OP0_OR   = 6'h25;
  localparam logic [5:0] OP0_XOR  = 6'h26;
  localparam logic [5:0] OP0_NOR  = 6'h27;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  localparam logic [1:0] SRC2_RT   = 2'd0;
  localparam logic [1:0] SRC2_SIMM = 2'd1;
  localparam logic [1:0] SRC2_ZIMM = 2'd2;

  // 48-bit FIFO entry; opcode and rsvd ride along
  // for debug and keep the entry byte-aligned.
  typedef struct packed {
    logic [2:0]  rsvd;
    logic [5:0]  opcode;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src2;
    logic        rd_src;
    logic        writeenable;
    logic        except;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } dec_entry_t;

endpackage

// File: rtl/mips_decode_stage_comb.sv
// Combinational opcode/funct decoder: inst -> decoded entry.
// Ports: inst (32-bit word in), entry (dec_entry_t out).
module mips_decode_comb
  import mips_decode_pkg::*;
(
  input  logic [31:0] inst,
  output dec_entry_t  entry
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       r_type;
  logic [2:0] alu_op;
  logic [1:0] src2;
  logic       rd_src;
  logic       legal;
  logic       unused_shamt;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign r_type = (op == OP_OTHER0);
  assign unused_shamt = ^inst[10:6];

  always_comb begin
    alu_op = ALU_NONE;
    src2   = SRC2_RT;
    rd_src = 1'b0;
    legal  = 1'b1;
    unique case (1'b1)
      r_type && (fn == OP0_ADD || fn == OP0_ADDU):
        alu_op = ALU_ADD;
      r_type && fn == OP0_SUB: alu_op = ALU_SUB;
      r_type && fn == OP0_AND: alu_op = ALU_AND;
      r_type && fn == OP0_OR:  alu_op = ALU_OR;
      r_type && fn == OP0_XOR: alu_op = ALU_XOR;
      r_type && fn == OP0_NOR: alu_op = ALU_NOR;
      op == OP_ADDI || op == OP_ADDIU: begin
        alu_op = ALU_ADD;
        src2   = SRC2_SIMM;
        rd_src = 1'b1;
      end
      op == OP_ANDI: begin
        alu_op = ALU_AND;
        src2   = SRC2_ZIMM;
        rd_src = 1'b1;
      end
      op == OP_ORI: begin
        alu_op = ALU_OR;
        src2   = SRC2_ZIMM;
        rd_src = 1'b1;
      end
      op == OP_XORI: begin
        alu_op = ALU_XOR;
        src2   = SRC2_ZIMM;
        rd_src = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    entry             = '0;
    entry.opcode      = op;
    entry.alu_op      = alu_op;
    entry.alu_src2    = src2;
    entry.rd_src      = rd_src;
    entry.writeenable = legal;
    entry.except      = ~legal;
    entry.wreg        = rd_src ? inst[20:16]
                               : inst[15:11];
    entry.rs          = inst[25:21];
    entry.rt          = inst[20:16];
    entry.imm         = inst[15:0];
  end

endmodule

// File: rtl/mips_decode_stage.sv
// Buffered MIPS decode stage: decode on in_inst, DEPTH-entry FIFO,
// valid/ready on both sides, flush, optional exception counter.
// Ports: clk, reset (sync, high), flush, in_valid/in_ready/in_inst,
// out_valid/out_ready, out_* decoded fields, exc_count.
// Option: DECODE_EXC_COUNT_EN enables the saturating exc_count.
module mips_decode_stage
  import mips_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_alu_op,
  output logic [1:0]       out_alu_src2,
  output logic             out_rd_src,
  output logic             out_writeenable,
  output logic             out_except,
  output logic [4:0]       out_wreg,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [15:0]      out_imm,
  output logic [CNT_W-1:0] exc_count
);

  localparam int AW = $clog2(DEPTH);

  dec_entry_t    dec;
  dec_entry_t    head;
  dec_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          unused_head;

  mips_decode_comb u_comb (
    .inst  (in_inst),
    .entry (dec)
  );

  // No full-bypass: a pop does not free a slot
  // for a push in the same cycle.
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Head is shown even when empty; consumers qualify
  // with out_valid.
  assign head            = mem[rd_ptr];
  assign out_alu_op      = head.alu_op;
  assign out_alu_src2    = head.alu_src2;
  assign out_rd_src      = head.rd_src;
  assign out_writeenable = head.writeenable;
  assign out_except      = head.except;
  assign out_wreg        = head.wreg;
  assign out_rs          = head.rs;
  assign out_rt          = head.rt;
  assign out_imm         = head.imm;
  assign unused_head     = ^{head.rsvd, head.opcode};

`ifdef DECODE_EXC_COUNT_EN
  logic [CNT_W-1:0] exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= '0;
    end else if (!flush && push && dec.except
                 && exc_q != '1) begin
      exc_q <= exc_q + CNT_W'(1);
    end
  end

  assign exc_count = exc_q;
`else
  assign exc_count = '0;
`endif

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered, back-pressured MIPS decode stage: accepts 32-bit instruction words on a valid/ready handshake, decodes the ALU-class subset into datapath controls and register fields, and buffers the results in a DEPTH-entry FIFO for the execute stage. It succeeds the combinational `mips_decode`, using the same control encodings. It adds field extraction, buffering, flush and an optional exception counter. It sits between instruction fetch and the ALU/register-file datapath.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- CNT_W, 8, exception counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous clear of FIFO contents; counter kept
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept (= FIFO not full)
- in_inst  in  32  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_alu_op  out  3  ALU operation
- out_alu_src2  out  2  0 reg rt, 1 sign-extended imm, 2 zero-extended imm
- out_rd_src  out  1  0 write rd, 1 write rt
- out_writeenable  out  1  register write
- out_except  out  1  unsupported instruction
- out_wreg  out  5  destination (rd or rt per rd_src)
- out_rs, out_rt  out  5 each  source fields
- out_imm  out  16  inst[15:0]
- exc_count  out  CNT_W  accepted-exception count

## Operation
- Fields: opcode=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- OP_OTHER0 (6'h00), writeenable=1, rd_src=0, src2=0. Funct decodes as follows:
  - ADD 6'h20 and ADDU 6'h21 → alu_op 2.
  - SUB 6'h22 → 3.
  - AND 6'h24 → 4.
  - OR 6'h25 → 5.
  - XOR 6'h26 → 7.
  - NOR 6'h27 → 6.
- Immediates, writeenable=1, rd_src=1:
  - ADDI 6'h08 and ADDIU 6'h09 → op 2, src2 1.
  - ANDI 6'h0c → op 4, src2 2.
  - ORI 6'h0d → op 5, src2 2.
  - XORI 6'h0e → op 7, src2 2.
- Any other opcode, or OP_OTHER0 with any other funct: except=1, writeenable=0, alu_op=0, src2=0, rd_src=0. Fields are still passed through.
- Push when in_valid&&in_ready. Pop when out_valid&&out_ready. Simultaneous push and pop are both performed; occupancy is unchanged.
- in_ready=0 when occupancy==DEPTH. There is no full-bypass: a pop in that cycle does not allow a push.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
- When empty, out_* data outputs show the stale head slot. Consumers must qualify with out_valid.
- flush takes priority over push and pop. The word offered that cycle is dropped, pointers and occupancy go to 0, and exc_count is not incremented by that word.
- reset takes priority over flush.

## Timing
- Reset values: in_ready=1, out_valid=0, exc_count=0, pointers/occupancy 0. FIFO data is don't-care but simulates as 0 (storage reset).
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N, when the FIFO was empty.
- in_ready is a registered-state function, independent of in_valid and out_ready in the same cycle.
- Head data is stable while out_valid&&!out_ready.
- Reset asserted mid-stream discards all entries at that edge. in_ready returns to 1 in the following cycle.

## Configuration
- DECODE_EXC_COUNT_EN defined: exc_count increments on every push with except=1. It saturates at 2^CNT_W−1 and clears only on reset.
- DECODE_EXC_COUNT_EN undefined: no counter register, exc_count tied to 0.

## Structure
- Shared package: opcode and funct constants (OP_OTHER0, OP_ADDI…, OP0_ADD…), ALU op encodings (ALU_ADD=2, ALU_SUB=3, ALU_AND=4, ALU_OR=5, ALU_NOR=6, ALU_XOR=7), src2 encodings, and a packed decoded-entry typedef (48 bits).
- One sub-module: `mips_decode_comb`, purely combinational opcode/funct → controls. Instantiated once on in_inst before the FIFO.

## Test plan
- After reset, push ADD r3,r1,r2 (32'h00221820), out_ready=1. Next cycle: out_valid=1, alu_op=2, src2=0, rd_src=0, we=1, wreg=3, except=0.
- Push ORI r5,r4,0x00FF (32'h348500FF). Output: alu_op=5, src2=2, rd_src=1, wreg=5, imm=16'h00FF, we=1.
- Hold out_ready=0 and push DEPTH words. in_ready drops to 0 after the DEPTH-th push. Then set out_ready=1: words drain in order, and a push is accepted only after the first pop.
- Push opcode 6'h01 and an OTHER0 word with funct 6'h08. Both produce except=1, we=0. With DECODE_EXC_COUNT_EN, exc_count=2; without it, exc_count=0.
- Simultaneous push/pop at occupancy 1 for 10 cycles: occupancy stays 1 and order is preserved.
- Assert flush with 2 entries queued and in_valid=1. Next cycle: out_valid=0, in_ready=1, exc_count unchanged. Asserting reset mid-stream gives the same result, with exc_count=0.
